sevenseg_scanner: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It consumes the 1 kHz square wave produced by the clock divider and steps one digit per rising edge of that wave, giving a 4 ms frame (250 Hz refresh). It snapshots the display value once per frame to prevent tearing, inserts an anode-off guard interval to suppress ghosting, and optionally blanks leading zeros.

---
 rtl/sevenseg_pkg.sv | 21 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/sevenseg_scanner.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    WAIT,
    BLANK,
    DRIVE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/sevenseg_scanner.sv
// Four-digit common-anode display scanner: one digit per 1 kHz tick, per-frame
// snapshot of the displayed data, anode-off guard interval and leading-zero blanking.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c1khz,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [9:0] BLANK_LAST = 10'(BLANK_CYCLES - 1);

  state_t      state, state_next;
  logic [9:0]  bcnt, bcnt_next;
  logic [1:0]  ptr, ptr_next;
  logic        c1k_q;
  logic        tick;
  logic [15:0] snap_value;
  logic [3:0]  snap_dp;
  logic        snap_lz;
  logic [3:0]  nibble;
  logic [6:0]  dec_seg;
  logic [3:0]  lead_zero;
  logic        blank_digit;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;
  logic        dp_next;

  assign tick = c1khz & ~c1k_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT;
      bcnt  <= '0;
      ptr   <= 2'd3;
    end else begin
      state <= state_next;
      bcnt  <= bcnt_next;
      ptr   <= ptr_next;
    end
  end

  // A tick in BLANK (only possible with an oversized guard) restarts the guard interval.
  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    ptr_next   = tick ? ptr + 2'd1 : ptr;
    case (state)
      WAIT: begin
        if (tick) begin
          state_next = BLANK;
          bcnt_next  = '0;
        end
      end
      BLANK: begin
        if (tick) begin
          bcnt_next = '0;
        end else if (bcnt == BLANK_LAST) begin
          state_next = DRIVE;
        end else begin
          bcnt_next = bcnt + 10'd1;
        end
      end
      DRIVE: begin
        if (tick) begin
          state_next = BLANK;
          bcnt_next  = '0;
        end
      end
      default: state_next = WAIT;
    endcase
  end

  // Snapshot is taken on the tick that moves the pointer onto digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c1k_q      <= 1'b0;
      snap_value <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
    end else begin
      c1k_q <= c1khz;
      if (tick && ptr == 2'd3) begin
        snap_value <= value;
        snap_dp    <= dp_mask;
        snap_lz    <= lz_en;
      end
    end
  end

  assign nibble = snap_value[{ptr, 2'b00} +: 4];

  hex_to_7seg u_decode (
    .digit (nibble),
    .seg   (dec_seg)
  );

  assign lead_zero[3] = (snap_value[15:12] == 4'd0);
  assign lead_zero[2] = lead_zero[3] && (snap_value[11:8] == 4'd0);
  assign lead_zero[1] = lead_zero[2] && (snap_value[7:4] == 4'd0);
  assign lead_zero[0] = 1'b0;
  assign blank_digit  = snap_lz && lead_zero[ptr];

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (state == DRIVE) begin
      an_next  = ~(4'b0001 << ptr);
      seg_next = blank_digit ? SEG_BLANK : dec_seg;
      dp_next  = ~snap_dp[ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
